// File: rtl/sched_pkg.sv
// Shared state type and default timing for the intersection scheduler.
// SCHED_PED_PHASE_EN adds the pedestrian WALK state to the enum.
package sched_pkg;
    localparam int DEF_N_APPR    = 4;
    localparam int DEF_MIN_GREEN = 5;
    localparam int DEF_MAX_GREEN = 20;
    localparam int DEF_YELLOW_T  = 3;
    localparam int DEF_ALLRED_T  = 2;
    localparam int DEF_WALK_T    = 6;

`ifdef SCHED_PED_PHASE_EN
    typedef enum logic [1:0] {ST_ALLRED, ST_GREEN, ST_YELLOW, ST_WALK} state_e;
`else
    typedef enum logic [1:0] {ST_ALLRED, ST_GREEN, ST_YELLOW} state_e;
`endif
endpackage

// File: rtl/intersection_scheduler_if.sv
// Sensor inputs and signal-head outputs of the intersection scheduler.
// SCHED_PED_PHASE_EN adds ped_req/walk.
interface intersection_scheduler_if #(
    parameter int N_APPR = 4
);
    localparam int IW = $clog2(N_APPR);

    logic              tick;
    logic [N_APPR-1:0] req;
    logic [N_APPR-1:0] grant;
    logic [N_APPR-1:0] yellow;
    logic              all_red;
    logic [IW-1:0]     cur_idx;
`ifdef SCHED_PED_PHASE_EN
    logic              ped_req;
    logic              walk;

    modport master (output tick, req, ped_req, input grant, yellow, all_red, cur_idx, walk);
    modport slave  (input tick, req, ped_req, output grant, yellow, all_red, cur_idx, walk);
`else
    modport master (output tick, req, input grant, yellow, all_red, cur_idx);
    modport slave  (input tick, req, output grant, yellow, all_red, cur_idx);
`endif
endinterface

// File: rtl/sched_rr_pick.sv
// Combinational round-robin pick: first pending approach strictly after cur_idx_i, wrapping.
module sched_rr_pick #(
    parameter int N_APPR = 4,
    parameter int IW     = $clog2(N_APPR)
) (
    input  logic [N_APPR-1:0] pending_i,
    input  logic [IW-1:0]     cur_idx_i,
    output logic              valid_o,
    output logic [IW-1:0]     next_idx_o
);
    always_comb begin
        logic [IW-1:0] j;
        valid_o    = 1'b0;
        next_idx_o = cur_idx_i;
        j          = '0;
        // Scan farthest-first so the nearest pending approach is the last write.
        for (int k = N_APPR; k >= 1; k--) begin
            j = IW'((int'(cur_idx_i) + k) % N_APPR);
            if (pending_i[j]) begin
                valid_o    = 1'b1;
                next_idx_o = j;
            end
        end
    end
endmodule

// File: rtl/intersection_scheduler.sv
// Round-robin traffic-light scheduler with min/max green, yellow and all-red clearance.
// Define SCHED_PED_PHASE_EN to add a pedestrian WALK phase (ped_req/walk, WALK_T).
module intersection_scheduler
    import sched_pkg::*;
#(
    parameter int N_APPR    = DEF_N_APPR,
    parameter int MIN_GREEN = DEF_MIN_GREEN,
    parameter int MAX_GREEN = DEF_MAX_GREEN,
    parameter int YELLOW_T  = DEF_YELLOW_T,
    parameter int ALLRED_T  = DEF_ALLRED_T
`ifdef SCHED_PED_PHASE_EN
    , parameter int WALK_T  = DEF_WALK_T
`endif
) (
    input logic                     clk,
    input logic                     reset,
    intersection_scheduler_if.slave bus
);
    localparam int IW = $clog2(N_APPR);
    localparam int CW = $clog2(MAX_GREEN + 1);

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [N_APPR-1:0] pend_q, pend_d;
    logic [N_APPR-1:0] grant_q, grant_d, yellow_q, yellow_d;
    logic [N_APPR-1:0] cur_oh, next_oh, others, green_mask;
    logic [IW-1:0]     idx_q, idx_d, rr_idx;
    logic              all_red_q, all_red_d, rr_valid;
    int                elapsed1;
`ifdef SCHED_PED_PHASE_EN
    logic              ped_pend_q, ped_pend_d, after_walk_q, after_walk_d, walk_q;
`endif

    sched_rr_pick #(.N_APPR(N_APPR), .IW(IW)) u_pick (
        .pending_i (pend_q),
        .cur_idx_i (idx_q),
        .valid_o   (rr_valid),
        .next_idx_o(rr_idx)
    );

    always_comb begin
        cur_oh        = '0;
        cur_oh[idx_q] = 1'b1;
    end
    assign others   = pend_q & ~cur_oh;
    assign elapsed1 = int'(cnt_q) + 1;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        if (bus.tick) begin
            case (state_q)
                ST_ALLRED: if (int'(cnt_q) >= ALLRED_T - 1) begin
                    if (rr_valid) begin
                        state_d = ST_GREEN;
                        idx_d   = rr_idx;
                    end
`ifdef SCHED_PED_PHASE_EN
                    // A walk phase pre-empts vehicles, but never twice in a row.
                    if (ped_pend_q && !after_walk_q) begin
                        state_d = ST_WALK;
                        idx_d   = idx_q;
                    end
`endif
                end
                ST_GREEN: if (|others && ((elapsed1 >= MIN_GREEN && !bus.req[idx_q]) ||
                                          elapsed1 >= MAX_GREEN))
                    state_d = ST_YELLOW;
                ST_YELLOW: if (int'(cnt_q) >= YELLOW_T - 1) state_d = ST_ALLRED;
`ifdef SCHED_PED_PHASE_EN
                ST_WALK: if (int'(cnt_q) >= WALK_T - 1) state_d = ST_ALLRED;
`endif
                default: state_d = ST_ALLRED;
            endcase
        end
    end

    always_comb begin
        next_oh        = '0;
        next_oh[idx_d] = 1'b1;
        green_mask     = (state_q == ST_GREEN) ? cur_oh : '0;
        pend_d         = pend_q | (bus.req & ~green_mask);
        if (state_d == ST_GREEN && state_q != ST_GREEN) pend_d = pend_d & ~next_oh;

        cnt_d = cnt_q;
        if (state_d != state_q) cnt_d = '0;
        else if (bus.tick && cnt_q != CW'(MAX_GREEN)) cnt_d = cnt_q + 1'b1;

        grant_d   = (state_d == ST_GREEN)  ? next_oh : '0;
        yellow_d  = (state_d == ST_YELLOW) ? next_oh : '0;
        all_red_d = !(state_d == ST_GREEN || state_d == ST_YELLOW);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_ALLRED;
            cnt_q     <= '0;
            pend_q    <= '0;
            idx_q     <= IW'(N_APPR - 1);
            grant_q   <= '0;
            yellow_q  <= '0;
            all_red_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pend_q    <= pend_d;
            idx_q     <= idx_d;
            grant_q   <= grant_d;
            yellow_q  <= yellow_d;
            all_red_q <= all_red_d;
        end
    end

    assign bus.grant   = grant_q;
    assign bus.yellow  = yellow_q;
    assign bus.all_red = all_red_q;
    assign bus.cur_idx = idx_q;

`ifdef SCHED_PED_PHASE_EN
    always_comb begin
        ped_pend_d = ped_pend_q | (bus.ped_req && state_q != ST_WALK);
        if (state_d == ST_WALK && state_q != ST_WALK) ped_pend_d = 1'b0;
        after_walk_d = after_walk_q;
        if (state_q == ST_WALK && state_d == ST_ALLRED) after_walk_d = 1'b1;
        else if (state_q == ST_ALLRED && state_d != ST_ALLRED) after_walk_d = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ped_pend_q   <= 1'b0;
            after_walk_q <= 1'b0;
            walk_q       <= 1'b0;
        end else begin
            ped_pend_q   <= ped_pend_d;
            after_walk_q <= after_walk_d;
            walk_q       <= (state_d == ST_WALK);
        end
    end

    assign bus.walk = walk_q;
`endif
endmodule
